// File: rtl/phy_rx_pkg.sv
// Shared types and constants for the 802.11a receive frame controller.
// Holds the rate table used to decode the SIGNAL field.
package phy_rx_pkg;

  localparam logic [3:0] RATE_6  = 4'b1011;
  localparam logic [3:0] RATE_9  = 4'b1111;
  localparam logic [3:0] RATE_12 = 4'b1010;
  localparam logic [3:0] RATE_18 = 4'b1110;
  localparam logic [3:0] RATE_24 = 4'b1001;
  localparam logic [3:0] RATE_36 = 4'b1101;
  localparam logic [3:0] RATE_48 = 4'b1000;
  localparam logic [3:0] RATE_54 = 4'b1100;

  localparam logic [1:0] MODE_R12 = 2'd0;
  localparam logic [1:0] MODE_R34 = 2'd1;
  localparam logic [1:0] MODE_R23 = 2'd2;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_RATE   = 2'd1;
  localparam logic [1:0] ERR_PARITY = 2'd2;
  localparam logic [1:0] ERR_FORMAT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SIGNAL,
    S_CHECK,
    S_DATA,
    S_DONE,
    S_ERROR
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] mode;
    logic [7:0] ndbps;
    logic [8:0] ncbps;
  } rate_info_t;

  typedef struct packed {
    logic        ok;
    logic [1:0]  err;
    logic [3:0]  rate;
    logic [11:0] length;
    logic [1:0]  mode;
    logic [7:0]  ndbps;
    logic [8:0]  ncbps;
  } sig_chk_t;

  function automatic rate_info_t rate_lookup(
    input logic [3:0] rate
  );
    rate_info_t r;
    case (rate)
      RATE_6:  r = '{1'b1, MODE_R12, 8'd24, 9'd48};
      RATE_9:  r = '{1'b1, MODE_R34, 8'd36, 9'd48};
      RATE_12: r = '{1'b1, MODE_R12, 8'd48, 9'd96};
      RATE_18: r = '{1'b1, MODE_R34, 8'd72, 9'd96};
      RATE_24: r = '{1'b1, MODE_R12, 8'd96, 9'd192};
      RATE_36: r = '{1'b1, MODE_R34, 8'd144, 9'd192};
      RATE_48: r = '{1'b1, MODE_R23, 8'd192, 9'd288};
      RATE_54: r = '{1'b1, MODE_R34, 8'd216, 9'd288};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/phy_signal_checker.sv
// Combinational decode and validation of the 24-bit SIGNAL field.
// Error priority: rate, then parity, then format.
module phy_signal_checker
  import phy_rx_pkg::*;
(
  input  logic [23:0] sig,
  output sig_chk_t    res
);

  rate_info_t info;

  always_comb begin
    info       = rate_lookup(sig[3:0]);
    res        = '0;
    res.rate   = sig[3:0];
    res.length = sig[16:5];
    res.mode   = info.mode;
    res.ndbps  = info.ndbps;
    res.ncbps  = info.ncbps;
    if (!info.valid)
      res.err = ERR_RATE;
    else if (^sig[17:0])
      res.err = ERR_PARITY;
    else if (sig[4] || (sig[23:18] != '0)
             || (sig[16:5] == '0))
      res.err = ERR_FORMAT;
    else
      res.ok = 1'b1;
  end

endmodule

// File: rtl/phy_rx_frame_ctrl.sv
// Receive frame controller: skips preamble, checks SIGNAL,
// forwards DATA coded bits with symbol/frame delimiters.
module phy_rx_frame_ctrl
  import phy_rx_pkg::*;
#(
  parameter int IN_W    = 1,
  parameter int PRE_LEN = 30,
  parameter int ACC_W   = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            rx_active,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [IN_W-1:0] out_data,
  output logic            out_valid,
  output logic            out_sym_last,
  output logic            out_last,
  output logic [1:0]      mode,
  output logic [34:0]     rxvector,
  output logic            rxvector_valid,
  output logic            rx_error,
  output logic [1:0]      err_code,
  output logic            rx_abort
);

  localparam int PRE_BEATS = PRE_LEN / IN_W;
  localparam int SIG_BEATS = 24 / IN_W;
  localparam int MAX_BEATS =
    (PRE_BEATS > SIG_BEATS) ? PRE_BEATS : SIG_BEATS;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  localparam logic [CNT_W-1:0] PRE_LAST =
    CNT_W'(PRE_BEATS - 1);
  localparam logic [CNT_W-1:0] SIG_LAST =
    CNT_W'(SIG_BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_START =
    (PRE_BEATS == 1) ? '0 : CNT_W'(1);
  localparam state_t FIRST =
    (PRE_BEATS == 1) ? S_SIGNAL : S_PREAMBLE;
  localparam logic [8:0] STEP = 9'(IN_W);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [23:0]      sig;
  logic [8:0]       sym_cnt, sym_nxt, ncbps;
  logic [7:0]       ndbps;
  logic [ACC_W-1:0] acc, acc_nxt, target;
  logic             fire, abort;
  logic             sym_end, frame_end;
  sig_chk_t         chk;

  phy_signal_checker u_chk (
    .sig (sig),
    .res (chk)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (enable) begin
      unique case (state)
        S_IDLE:
          if (fire && rx_active) state_n = FIRST;
        S_PREAMBLE:
          if (!rx_active) state_n = S_IDLE;
          else if (fire && cnt == PRE_LAST)
            state_n = S_SIGNAL;
        S_SIGNAL:
          if (!rx_active) state_n = S_IDLE;
          else if (fire && cnt == SIG_LAST)
            state_n = S_CHECK;
        S_CHECK:
          if (!rx_active) state_n = S_IDLE;
          else if (chk.ok) state_n = S_DATA;
          else state_n = S_ERROR;
        S_DATA:
          if (!rx_active) state_n = S_IDLE;
          else if (fire && frame_end)
            state_n = S_DONE;
        S_DONE, S_ERROR:
          if (!rx_active) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == S_IDLE) || (state == S_PREAMBLE)
             || (state == S_SIGNAL) || (state == S_DATA);
    fire      = in_valid && in_ready && enable;
    abort     = enable && !rx_active
             && ((state == S_PREAMBLE) || (state == S_SIGNAL)
             ||  (state == S_CHECK) || (state == S_DATA));
    sym_nxt   = sym_cnt + STEP;
    sym_end   = (sym_nxt == ncbps);
    acc_nxt   = acc + ACC_W'(ndbps);
    frame_end = sym_end && (acc_nxt >= target);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt            <= '0;
      sig            <= '0;
      sym_cnt        <= '0;
      acc            <= '0;
      target         <= '0;
      ndbps          <= '0;
      ncbps          <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_sym_last   <= 1'b0;
      out_last       <= 1'b0;
      mode           <= MODE_R12;
      rxvector       <= '0;
      rxvector_valid <= 1'b0;
      rx_error       <= 1'b0;
      err_code       <= ERR_NONE;
      rx_abort       <= 1'b0;
    end else begin
      // Strobes last one cycle and never repeat while frozen.
      out_valid      <= 1'b0;
      out_sym_last   <= 1'b0;
      out_last       <= 1'b0;
      rxvector_valid <= 1'b0;
      rx_error       <= 1'b0;
      rx_abort       <= 1'b0;
      if (enable) begin
        rx_abort <= abort;
        unique case (state)
          S_IDLE:
            if (fire && rx_active) begin
              cnt      <= CNT_START;
              err_code <= ERR_NONE;
            end
          S_PREAMBLE:
            if (fire && rx_active)
              cnt <= (cnt == PRE_LAST) ? '0 : cnt + 1'b1;
          S_SIGNAL:
            if (fire && rx_active) begin
              sig <= {in_data, sig[23:IN_W]};
              cnt <= (cnt == SIG_LAST) ? '0 : cnt + 1'b1;
            end
          S_CHECK:
            if (rx_active) begin
              if (chk.ok) begin
                mode     <= chk.mode;
                ndbps    <= chk.ndbps;
                ncbps    <= chk.ncbps;
                target   <= ACC_W'(22)
                          + ACC_W'({chk.length, 3'b000});
                rxvector <= {chk.length, 3'b000,
                             chk.rate, 16'h0000};
                rxvector_valid <= 1'b1;
              end else begin
                rx_error <= 1'b1;
                err_code <= chk.err;
              end
            end
          S_DATA:
            if (fire && rx_active) begin
              out_data     <= in_data;
              out_valid    <= 1'b1;
              out_sym_last <= sym_end;
              out_last     <= frame_end;
              sym_cnt      <= sym_end ? '0 : sym_nxt;
              if (sym_end) acc <= acc_nxt;
            end
          default: ;
        endcase
        if (state_n == S_IDLE) begin
          cnt     <= '0;
          sym_cnt <= '0;
          acc     <= '0;
        end
      end
    end
  end

endmodule

// File: doc/phy_rx_frame_ctrl.md
Name: phy_rx_frame_ctrl

Overview:
- Parametrised receive-side frame controller for the 802.11a PHY.
- Consumes demodulated coded bits IN_W per beat and skips a configurable preamble.
- Captures and validates the 24-bit SIGNAL field (rate, reserved bit, parity, tail, length) and publishes RXVECTOR and code mode.
- Forwards exactly Nsym×NCBPS DATA coded bits to the deinterleaver path, with symbol and frame delimiters and error reporting.

Parameters:
IN_W, 1, bits per input beat; legal values 1, 2, 4, 8.
PRE_LEN, 30, preamble length in bits; must be a multiple of IN_W.
ACC_W, 16, width of the data-bit accumulator; must hold 22+8×4095+216.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  low freezes all state; no beat is consumed.
rx_active  in  1  frame envelope; level signal, high for the duration of a received frame.
in_data  in  IN_W  coded bits; in_data[0] is the earliest bit in time.
in_valid  in  1  beat valid.
in_ready  out  1  a beat is consumed when in_valid && in_ready && enable.
out_data  out  IN_W  forwarded DATA coded bits, same bit order as in_data.
out_valid  out  1  out_data valid.
out_sym_last  out  1  last beat of an OFDM symbol (NCBPS boundary).
out_last  out  1  last beat of the frame.
mode  out  2  0 = r1/2, 1 = r3/4, 2 = r2/3; held until the next frame's CHECK.
rxvector  out  35  {length[11:0], rssi 3'b000, rate[3:0], service 16'h0000}.
rxvector_valid  out  1  one-cycle pulse.
rx_error  out  1  one-cycle pulse.
err_code  out  2  1 = bad rate, 2 = parity, 3 = format; held with rx_error until the next frame.
rx_abort  out  1  one-cycle pulse when rx_active drops before the frame completes.

Behaviour:
- Reset: state IDLE, all counters 0, every output 0; in_ready = 1.
- States: IDLE, PREAMBLE, SIGNAL, CHECK, DATA, DONE, ERROR.
- IDLE: the first consumed beat with rx_active = 1 counts as preamble beat 0 and moves to PREAMBLE. If PRE_LEN == IN_W, that beat completes the preamble and the next state is SIGNAL.
- PREAMBLE: preamble bits are discarded. After PRE_LEN/IN_W consumed beats → SIGNAL.
- SIGNAL: shift bits into sig[23:0], earliest bit at sig[0]. After 24/IN_W beats → CHECK. in_ready = 0 from the cycle after the last SIGNAL beat.
- CHECK (exactly 1 cycle, in_ready = 0):
  - Field layout: rate = sig[3:0], reserved = sig[4], length = sig[16:5], parity = sig[17], tail = sig[23:18].
  - Error priority:
    - rate not in {1011, 1111, 1010, 1110, 1001, 1101, 1000, 1100} → err 1;
    - else XOR of sig[17:0] != 0 → err 2;
    - else reserved != 0, tail != 0, or length == 0 → err 3.
  - On error: pulse rx_error, → ERROR.
  - Otherwise: register mode, NDBPS, NCBPS, target = 22 + 8×length, and rxvector; pulse rxvector_valid; → DATA.
- Rate table (rate code: NDBPS/NCBPS, mode):
  - 1011: 24/48, 0.
  - 1111: 36/48, 1.
  - 1010: 48/96, 0.
  - 1110: 72/96, 1.
  - 1001: 96/192, 0.
  - 1101: 144/192, 1.
  - 1000: 192/288, 2.
  - 1100: 216/288, 1.
- DATA:
  - Each consumed beat appears on out_data/out_valid exactly 1 cycle later; no bubbles are inserted and no beats are reordered.
  - sym_cnt advances by IN_W per beat. At sym_cnt + IN_W == NCBPS: assert out_sym_last, clear sym_cnt, and add NDBPS to acc.
  - If acc + NDBPS >= target at that boundary, also assert out_last and → DONE.
  - Total forwarded bits = ceil(target/NDBPS) × NCBPS.
- DONE / ERROR: in_ready = 0; wait for rx_active == 0, then → IDLE. Counters and acc are cleared on entry to IDLE.
- Abort: rx_active == 0 on any cycle in PREAMBLE, SIGNAL, CHECK, or DATA → pulse rx_abort, → IDLE. A pending DATA beat is still output (1-cycle pipeline drains) but never with out_last.
- enable == 0: state, counters, and outputs held; pulses do not repeat.
- rx_active re-asserting while in DONE or ERROR has no effect until the machine has returned to IDLE.
- Reset mid-frame: reset wins over all other inputs; the next cycle matches reset values.
- Widths: acc and target are ACC_W bits unsigned; no overflow is possible for length <= 4095.

Decomposition:
- Package phy_rx_pkg holds:
  - rate code constants;
  - mode encoding (0/1/2);
  - err_code constants;
  - state encoding;
  - function rate_lookup(rate) returning {valid, mode, NDBPS, NCBPS}.
- Sub-module phy_signal_checker: combinational check of sig[23:0] producing {ok, err_code, rate, length, mode, ndbps, ncbps}, registered by the parent in CHECK.

Test Plan:
1. IN_W=1, PRE_LEN=30, SIGNAL rate 1011, length 1, valid parity → rxvector = {12'd1, 3'b0, 4'b1011, 16'h0} pulses once; mode = 0; 96 DATA beats forwarded; out_sym_last on beats 48 and 96; out_last on beat 96.
2. IN_W=4, rate 1100, length 100 (target 822) → 4 symbols, 1152 bits = 288 beats; out_sym_last every 72 beats; out_last on beat 288; mode = 1.
3. Rate 1000, length 4095, IN_W=8 → target 32782; 171 symbols; 6156 beats; mode = 2; acc never wraps.
4. SIGNAL with a single parity bit flipped → rx_error with err_code = 2; no rxvector_valid, no out_valid; IDLE after rx_active falls. Rate 0000 → err_code = 1 (rate error wins over simultaneous parity error). Tail = 6'b000001 → err_code = 3.
5. rx_active dropped at DATA beat 10 of test 1 → rx_abort pulse; 10 beats output, none with out_last; a following valid frame decodes correctly.
6. enable low for 5 cycles mid-SIGNAL and in_valid gaps during DATA → results identical to test 1. reset asserted mid-DATA → all outputs 0 next cycle, state IDLE.
